// File: rtl/frac_baud_gen.sv
// rtl/frac_baud_gen.sv - fractional-divisor oversample/bit/mid-bit tick generator
module frac_baud_gen #(
    parameter int OSR    = 16,
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int IDX_W  = $clog2(OSR)
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              en_i,
    input  logic              sync_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    input  logic              div_we_i,
    output logic              div_pend_o,
    output logic              osr_tick_o,
    output logic              bit_tick_o,
    output logic              mid_tick_o,
    output logic [IDX_W-1:0]  osr_idx_o
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OSR - 1);
    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OSR / 2);

    logic [DIV_W-1:0]  int_r;
    logic [FRAC_W-1:0] frac_r;
    logic [DIV_W-1:0]  sh_int;
    logic [FRAC_W-1:0] sh_frac;
    logic              pend;
    logic [DIV_W:0]    cnt;
    logic [FRAC_W-1:0] acc;
    logic [IDX_W-1:0]  idx;

    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W:0]    period;
    logic [DIV_W:0]    last_cnt;
    logic              running;
    logic              hit;
    logic [IDX_W-1:0]  idx_next;
    logic              boundary;

    // The carry out of the fractional accumulator stretches this interval by one cycle.
    assign acc_sum  = {1'b0, acc} + {1'b0, frac_r};
    assign period   = {1'b0, int_r} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
    assign last_cnt = period - {{DIV_W{1'b0}}, 1'b1};
    assign running  = (int_r != '0);
    assign hit      = running && (cnt == last_cnt);
    assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    assign boundary = hit && (idx_next == '0);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            int_r      <= '0;
            frac_r     <= '0;
            sh_int     <= '0;
            sh_frac    <= '0;
            pend       <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            idx        <= '0;
            osr_tick_o <= 1'b0;
            bit_tick_o <= 1'b0;
            mid_tick_o <= 1'b0;
        end else if (div_we_i && !en_i) begin
            int_r      <= div_int_i;
            frac_r     <= div_frac_i;
            pend       <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            idx        <= '0;
            osr_tick_o <= 1'b0;
            bit_tick_o <= 1'b0;
            mid_tick_o <= 1'b0;
        end else if (!en_i) begin
            cnt        <= '0;
            acc        <= '0;
            idx        <= '0;
            osr_tick_o <= 1'b0;
            bit_tick_o <= 1'b0;
            mid_tick_o <= 1'b0;
            // Nothing is being timed while disabled, so a parked divisor can land now.
            if (pend) begin
                int_r  <= sh_int;
                frac_r <= sh_frac;
                pend   <= 1'b0;
            end
        end else begin
            osr_tick_o <= 1'b0;
            bit_tick_o <= 1'b0;
            mid_tick_o <= 1'b0;
            if (div_we_i) begin
                sh_int  <= div_int_i;
                sh_frac <= div_frac_i;
                pend    <= 1'b1;
            end
            if (sync_i) begin
                cnt <= '0;
                acc <= '0;
                idx <= '0;
            end else if (hit) begin
                cnt        <= '0;
                idx        <= idx_next;
                osr_tick_o <= 1'b1;
                bit_tick_o <= boundary;
                mid_tick_o <= (idx_next == IDX_MID);
                if (boundary && (div_we_i || pend)) begin
                    int_r  <= div_we_i ? div_int_i : sh_int;
                    frac_r <= div_we_i ? div_frac_i : sh_frac;
                    acc    <= '0;
                    pend   <= 1'b0;
                end else begin
                    acc <= acc_sum[FRAC_W-1:0];
                end
            end else if (running) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    assign div_pend_o = pend;
    assign osr_idx_o  = idx;

endmodule

// File: tb/tb_frac_baud_gen.sv
// tb/tb_frac_baud_gen.sv - directed vector bench for frac_baud_gen
module tb_frac_baud_gen;

    localparam int OSR = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        sync = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        div_we = 1'b0;
    logic        div_pend;
    logic        osr_tick;
    logic        bit_tick;
    logic        mid_tick;
    logic [3:0]  osr_idx;

    frac_baud_gen #(.OSR(16), .DIV_W(16), .FRAC_W(4), .IDX_W(4)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .en_i       (en),
        .sync_i     (sync),
        .div_int_i  (div_int),
        .div_frac_i (div_frac),
        .div_we_i   (div_we),
        .div_pend_o (div_pend),
        .osr_tick_o (osr_tick),
        .bit_tick_o (bit_tick),
        .mid_tick_o (mid_tick),
        .osr_idx_o  (osr_idx)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    typedef struct {
        int di;
        int df;
        int n;
        int exp_cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        en      = 1'b0;
        sync    = 1'b0;
        div_we  = 1'b0;
        step;
        step;
        reset_n = 1'b1;
    endtask

    task automatic write_idle(input int i, input int f);
        en       = 1'b0;
        div_int  = i[15:0];
        div_frac = f[3:0];
        div_we   = 1'b1;
        step;
        div_we   = 1'b0;
    endtask

    task automatic wait_tick(input int start, input int limit, output int gap);
        gap = start;
        do begin
            step;
            gap++;
        end while (!osr_tick && gap < limit);
    endtask

    int cyc, ticks, bad, g, exp_idx, found, hi, bits;

    initial begin
        // int, frac, ticks observed, cycles from enable to the last of them
        vecs[0] = '{4, 0, 32, 128};
        vecs[1] = '{4, 8, 16, 72};
        vecs[2] = '{1, 0, 16, 16};
        vecs[3] = '{3, 4, 16, 52};
        vecs[4] = '{2, 15, 16, 47};
        vecs[5] = '{5, 1, 16, 81};

        @(negedge clk);
        do_reset;
        check("rst_osr_tick", int'(osr_tick), 0);
        check("rst_bit_tick", int'(bit_tick), 0);
        check("rst_mid_tick", int'(mid_tick), 0);
        check("rst_idx", int'(osr_idx), 0);
        check("rst_pend", int'(div_pend), 0);
        en = 1'b1;
        ticks = 0;
        for (int k = 0; k < 20; k++) begin
            step;
            ticks += int'(osr_tick);
        end
        check("rst_stopped_ticks", ticks, 0);
        en = 1'b0;

        for (int v = 0; v < 6; v++) begin
            do_reset;
            write_idle(vecs[v].di, vecs[v].df);
            en = 1'b1;
            ticks = 0;
            cyc = 0;
            bad = 0;
            while (ticks < vecs[v].n && cyc < 4000) begin
                step;
                cyc++;
                if (osr_tick) begin
                    ticks++;
                    exp_idx = ticks % OSR;
                    if (int'(osr_idx) != exp_idx || bit_tick != (exp_idx == 0) ||
                        mid_tick != (exp_idx == OSR / 2))
                        bad++;
                end else if (bit_tick || mid_tick) begin
                    bad++;
                end
            end
            check($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cycles);
            check($sformatf("vec%0d_phase_errors", v), bad, 0);
            en = 1'b0;
        end

        // Pending divisor write lands on the bit boundary
        do_reset;
        write_idle(4, 0);
        en = 1'b1;
        cyc = 0;
        while (!(osr_tick && osr_idx == 4'd3) && cyc < 200) begin
            step;
            cyc++;
        end
        check("pend_reach_idx3", int'(osr_tick && osr_idx == 4'd3), 1);
        div_int = 16'd8;
        div_we  = 1'b1;
        step;
        div_we  = 1'b0;
        check("pend_rise", int'(div_pend), 1);
        bad = 0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            wait_tick((k == 0) ? 1 : 0, 20, g);
            if (!osr_tick) begin
                bad++;
                break;
            end
            if (bit_tick) begin
                found = 1;
                check("pend_gap_at_boundary", g, 4);
                check("pend_fall", int'(div_pend), 0);
            end else if (g != 4 || !div_pend) begin
                bad++;
            end
        end
        check("pend_boundary_seen", found, 1);
        check("pend_old_gaps", bad, 0);
        wait_tick(0, 20, g);
        check("pend_new_gap", g, 8);

        // Phase re-sync mid-interval
        do_reset;
        write_idle(4, 0);
        en = 1'b1;
        cyc = 0;
        while (!(osr_tick && osr_idx == 4'd9) && cyc < 200) begin
            step;
            cyc++;
        end
        check("sync_reach_idx9", int'(osr_tick && osr_idx == 4'd9), 1);
        step;
        step;
        sync = 1'b1;
        step;
        check("sync_no_tick", int'(osr_tick), 0);
        check("sync_idx_cleared", int'(osr_idx), 0);
        sync = 1'b0;
        wait_tick(0, 20, g);
        check("sync_gap", g, 4);
        check("sync_idx", int'(osr_idx), 1);
        check("sync_no_bit", int'(bit_tick), 0);

        // Divide-by-one runs every cycle; writing zero stops after the next boundary
        do_reset;
        write_idle(1, 0);
        en = 1'b1;
        hi = 0;
        bits = 0;
        for (int k = 0; k < 32; k++) begin
            step;
            hi += int'(osr_tick);
            bits += int'(bit_tick);
        end
        check("div1_ticks", hi, 32);
        check("div1_bits", bits, 2);
        div_int = 16'd0;
        div_we  = 1'b1;
        step;
        div_we  = 1'b0;
        cyc = 0;
        while (!bit_tick && cyc < 40) begin
            step;
            cyc++;
        end
        check("div0_boundary_seen", int'(bit_tick), 1);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            step;
            hi += int'(osr_tick | bit_tick | mid_tick);
        end
        check("div0_quiet", hi, 0);
        check("div0_pend", int'(div_pend), 0);

        // Reset while a write is pending discards it
        do_reset;
        write_idle(4, 0);
        en = 1'b1;
        wait_tick(0, 20, g);
        step;
        div_int = 16'd8;
        div_we  = 1'b1;
        step;
        div_we  = 1'b0;
        check("rstp_pend_before", int'(div_pend), 1);
        step;
        reset_n = 1'b0;
        step;
        reset_n = 1'b1;
        check("rstp_ticks", int'(osr_tick | bit_tick | mid_tick), 0);
        check("rstp_idx", int'(osr_idx), 0);
        check("rstp_pend", int'(div_pend), 0);
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            step;
            hi += int'(osr_tick) + int'(div_pend);
        end
        check("rstp_stopped", hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
